// File: rtl/agc_pwm_meas_if.sv
// rtl/agc_pwm_meas_if.sv - PWM measurement bundle: input waveform, controls and result
//
// Purpose: groups the PWM input, measurement controls and the result
// strobe/value/lock of agc_pwm_meas into one bundle.
// Signals:
//   pwm_in    asynchronous PWM waveform
//   pwm_inv   1 = waveform is active-low
//   meas_en   measurement enable
//   avg_prd   averaging depth, 2^avg_prd frames
//   lock_tol  max |new - previous| counted as in-tolerance
//   pwm_val   averaged high-count, 0..2^PRD_W
//   pwm_vld   one-cycle strobe when pwm_val updates
//   pwm_lock  measurement stable
// Modports: master drives the waveform/controls, slave (the meter) drives results.
interface agc_pwm_meas_if #(
  parameter int PRD_W = 7
);
  logic           pwm_in;
  logic           pwm_inv;
  logic           meas_en;
  logic [1:0]     avg_prd;
  logic [3:0]     lock_tol;
  logic [PRD_W:0] pwm_val;
  logic           pwm_vld;
  logic           pwm_lock;

  modport master (
    output pwm_in, pwm_inv, meas_en, avg_prd, lock_tol,
    input  pwm_val, pwm_vld, pwm_lock
  );

  modport slave (
    input  pwm_in, pwm_inv, meas_en, avg_prd, lock_tol,
    output pwm_val, pwm_vld, pwm_lock
  );
endinterface

// File: rtl/agc_pwm_meas.sv
// rtl/agc_pwm_meas.sv - recovers the AGC gain value from a PWM waveform
//
// Purpose: measures the high-time of a PWM waveform over frames of
// 2^PRD_W clocks, averages over 2^avg_prd frames and flags lock once
// LOCK_CNT consecutive results agree within lock_tol.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    agc_pwm_meas_if.slave: pwm_in/pwm_inv/meas_en/avg_prd/lock_tol in,
//          pwm_val/pwm_vld/pwm_lock out
module agc_pwm_meas #(
  parameter int PRD_W    = 7,
  parameter int LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  agc_pwm_meas_if.slave bus
);
  localparam int VW = PRD_W + 1;
  localparam int AW = PRD_W + 4;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [PRD_W-1:0] FC_MAX  = '1;
  // Timeout spans two frames: 0 .. 2*2^PRD_W-1.
  localparam logic [PRD_W:0]   TMO_MAX = '1;
  localparam logic [LW-1:0]    LOCK_SAT = LW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, SYNC, MEAS} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s_prev_q;
  logic [PRD_W-1:0] fc_q, fc_d;
  logic [PRD_W:0]   tmo_q, tmo_d;
  logic [VW-1:0]    hi_q, hi_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [2:0]       frm_q, frm_d;
  logic [1:0]       avg_q, avg_d;
  logic [VW-1:0]    val_q, val_d;
  logic             vld_q, vld_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic             have_q, have_d;

  logic          s;
  logic          rise;
  logic [AW-1:0] total;
  logic [VW-1:0] result;
  logic [VW-1:0] diff;
  logic          last_frame;

  assign s     = s2_q ^ bus.pwm_inv;
  assign rise  = s & ~s_prev_q;
  // Frame total includes the level of the final frame cycle itself.
  assign total  = acc_q + AW'(hi_q) + AW'(s);
  assign result = VW'(total >> avg_q);
  assign diff   = (result >= val_q) ? (result - val_q) : (val_q - result);
  assign last_frame = (frm_q == 3'((1 << avg_q) - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s_prev_q <= 1'b0;
      fc_q     <= '0;
      tmo_q    <= '0;
      hi_q     <= '0;
      acc_q    <= '0;
      frm_q    <= '0;
      avg_q    <= '0;
      val_q    <= '0;
      vld_q    <= 1'b0;
      lcnt_q   <= '0;
      have_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= bus.pwm_in;
      s2_q     <= s1_q;
      s_prev_q <= s;
      fc_q     <= fc_d;
      tmo_q    <= tmo_d;
      hi_q     <= hi_d;
      acc_q    <= acc_d;
      frm_q    <= frm_d;
      avg_q    <= avg_d;
      val_q    <= val_d;
      vld_q    <= vld_d;
      lcnt_q   <= lcnt_d;
      have_q   <= have_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    tmo_d   = tmo_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    frm_d   = frm_q;
    avg_d   = avg_q;
    val_d   = val_q;
    vld_d   = 1'b0;
    lcnt_d  = lcnt_q;
    have_d  = have_q;
    if (!bus.meas_en) begin
      // Abort: drop partial work and lock history, keep the last result.
      state_d = IDLE;
      fc_d    = '0;
      tmo_d   = '0;
      hi_d    = '0;
      acc_d   = '0;
      frm_d   = '0;
      lcnt_d  = '0;
      have_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SYNC;
          tmo_d   = '0;
        end
        SYNC: begin
          acc_d = '0;
          frm_d = '0;
          avg_d = bus.avg_prd;
          if (rise) begin
            // The edge cycle is frame cycle 0 and is high by definition.
            state_d = MEAS;
            fc_d    = PRD_W'(1);
            hi_d    = VW'(1);
          end else if (tmo_q == TMO_MAX) begin
            // Constant level: start free-running frames next cycle.
            state_d = MEAS;
            fc_d    = '0;
            hi_d    = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        MEAS: begin
          if (fc_q == FC_MAX) begin
            fc_d = '0;
            hi_d = '0;
            if (last_frame) begin
              val_d  = result;
              vld_d  = 1'b1;
              acc_d  = '0;
              frm_d  = '0;
              avg_d  = bus.avg_prd;
              have_d = 1'b1;
              if (have_q && (diff <= VW'(bus.lock_tol))) begin
                lcnt_d = (lcnt_q == LOCK_SAT) ? lcnt_q : lcnt_q + 1'b1;
              end else begin
                lcnt_d = '0;
              end
            end else begin
              acc_d = total;
              frm_d = frm_q + 1'b1;
            end
          end else begin
            fc_d = fc_q + 1'b1;
            hi_d = hi_q + VW'(s);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.pwm_val  = val_q;
  assign bus.pwm_vld  = vld_q;
  assign bus.pwm_lock = (lcnt_q == LOCK_SAT);
endmodule

// File: tb/tb_agc_pwm_meas.sv
// tb/tb_agc_pwm_meas.sv - directed scoreboard bench for agc_pwm_meas
module tb_agc_pwm_meas;
  localparam int LOCK_CNT = 4;

  logic clk;
  logic reset;

  agc_pwm_meas_if #(.PRD_W(7)) bus ();

  agc_pwm_meas #(.PRD_W(7), .LOCK_CNT(LOCK_CNT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;
  int cyc       = 0;

  int exp_val[$];
  bit exp_lock[$];

  int pat[8];
  int plen = 1;
  bit gen_on = 0;
  int gph = 0;
  int gfr = 0;

  int cfg_avg = 0;
  int cfg_tol = 0;
  bit cfg_inv = 0;
  int m_prev = 0;
  bit m_have = 0;
  int m_cnt = 0;
  int sb_frm = 0;

  int first_vld = -1;
  int last_vld = 0;
  int prev_vld = 0;
  int vld_seen = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    int ev;
    bit el;
    if (gen_on) begin
      bus.pwm_in = (gph < pat[gfr % plen]);
      gph++;
      if (gph == 128) begin
        gph = 0;
        gfr++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bus.pwm_vld === 1'b1) begin
      vld_seen++;
      prev_vld = last_vld;
      last_vld = cyc;
      if (first_vld < 0) first_vld = cyc;
      if (exp_val.size() == 0) begin
        check("vld_with_empty_sb", {31'b0, bus.pwm_vld}, 0);
      end else begin
        ev = exp_val.pop_front();
        el = exp_lock.pop_front();
        check("pwm_val", {24'b0, bus.pwm_val}, ev);
        check("pwm_lock", {31'b0, bus.pwm_lock}, {31'b0, el});
      end
    end
  endtask

  task automatic push_results(input int nres);
    for (int r = 0; r < nres; r++) begin
      int sum;
      int v;
      int d;
      sum = 0;
      for (int k = 0; k < (1 << cfg_avg); k++) begin
        int h;
        h = pat[sb_frm % plen];
        if (cfg_inv) h = 128 - h;
        sum += h;
        sb_frm++;
      end
      v = sum >> cfg_avg;
      d = v - m_prev;
      if (d < 0) d = -d;
      if (m_have && d <= cfg_tol) begin
        if (m_cnt < LOCK_CNT) m_cnt++;
      end else begin
        m_cnt = 0;
      end
      m_have = 1;
      m_prev = v;
      exp_val.push_back(v);
      exp_lock.push_back(m_cnt == LOCK_CNT);
    end
  endtask

  task automatic start(input bit inv, input int avg, input int tol, input bit lvl);
    bus.meas_en  = 1'b0;
    gen_on       = 0;
    bus.pwm_in   = lvl;
    bus.pwm_inv  = inv;
    bus.avg_prd  = 2'(avg);
    bus.lock_tol = 4'(tol);
    cfg_inv = inv;
    cfg_avg = avg;
    cfg_tol = tol;
    repeat (6) tick();
    m_have = 0;
    m_cnt = 0;
    m_prev = 0;
    sb_frm = 0;
    gph = 0;
    gfr = 0;
    first_vld = -1;
    vld_seen = 0;
    start_cyc = cyc;
    gen_on = 1;
    bus.meas_en = 1'b1;
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (exp_val.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    check("sb_drained", exp_val.size(), 0);
    exp_val.delete();
    exp_lock.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.pwm_in = 1'b0;
    bus.pwm_inv = 1'b0;
    bus.meas_en = 1'b0;
    bus.avg_prd = 2'd0;
    bus.lock_tol = 4'd0;
    repeat (3) tick();
    check("reset_val", {24'b0, bus.pwm_val}, 0);
    check("reset_vld", {31'b0, bus.pwm_vld}, 0);
    check("reset_lock", {31'b0, bus.pwm_lock}, 0);
    reset = 1'b0;

    // Duty 32/128, single-frame averaging.
    pat[0] = 32; plen = 1;
    start(0, 0, 0, 0);
    push_results(4);
    run_until_empty(1000);
    bus.meas_en = 1'b0;
    check("first_vld_latency_130_131",
          {31'b0, (first_vld - start_cyc >= 130) && (first_vld - start_cyc <= 131)}, 1);
    check("vld_interval_avg0", last_vld - prev_vld, 128);

    // Active-low input: complement of duty 32.
    start(1, 0, 0, 0);
    push_results(3);
    run_until_empty(1000);
    bus.meas_en = 1'b0;

    // Held low: SYNC times out, value 0.
    pat[0] = 0; plen = 1;
    start(0, 0, 0, 0);
    push_results(2);
    run_until_empty(1000);
    bus.meas_en = 1'b0;
    check("timeout_latency_low", first_vld - start_cyc, 385);

    // Held high: timeout, value 128.
    pat[0] = 128; plen = 1;
    start(0, 0, 0, 1);
    push_results(2);
    run_until_empty(1000);
    bus.meas_en = 1'b0;
    check("timeout_latency_high", first_vld - start_cyc, 385);

    // Four-frame averaging.
    pat[0] = 30; pat[1] = 34; pat[2] = 31; pat[3] = 33; plen = 4;
    start(0, 2, 0, 0);
    push_results(2);
    run_until_empty(1500);
    bus.meas_en = 1'b0;
    check("vld_interval_avg2", last_vld - prev_vld, 512);

    // Truncation: 121/4 -> 30.
    pat[0] = 30; pat[1] = 30; pat[2] = 30; pat[3] = 31; plen = 4;
    start(0, 2, 0, 0);
    push_results(1);
    run_until_empty(1000);
    bus.meas_en = 1'b0;

    // Lock on alternating 40/42, then step to 60 drops lock.
    pat[0] = 40; pat[1] = 42; pat[2] = 40; pat[3] = 42;
    pat[4] = 40; pat[5] = 42; pat[6] = 60; pat[7] = 60; plen = 8;
    start(0, 0, 2, 0);
    push_results(8);
    run_until_empty(1500);
    bus.meas_en = 1'b0;

    // Abort mid-frame after lock.
    pat[0] = 50; plen = 1;
    start(0, 0, 0, 0);
    push_results(5);
    run_until_empty(1000);
    repeat (100) tick();
    bus.meas_en = 1'b0;
    vld_seen = 0;
    repeat (300) tick();
    check("abort_no_vld", vld_seen, 0);
    check("abort_val_hold", {24'b0, bus.pwm_val}, 50);
    check("abort_lock_clear", {31'b0, bus.pwm_lock}, 0);
    pat[0] = 70; plen = 1;
    start(0, 0, 0, 0);
    push_results(2);
    run_until_empty(1000);
    bus.meas_en = 1'b0;

    // Reset mid-measurement.
    pat[0] = 20; plen = 1;
    start(0, 0, 0, 0);
    push_results(1);
    run_until_empty(1000);
    repeat (50) tick();
    reset = 1'b1;
    bus.meas_en = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_val", {24'b0, bus.pwm_val}, 0);
    check("rst_vld", {31'b0, bus.pwm_vld}, 0);
    check("rst_lock", {31'b0, bus.pwm_lock}, 0);
    vld_seen = 0;
    repeat (300) tick();
    check("rst_no_vld", vld_seen, 0);
    start(0, 0, 0, 0);
    push_results(2);
    run_until_empty(1000);
    bus.meas_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/agc_pwm_meas.md
Name: agc_pwm_meas

Overview:
- Receive-side counterpart of the AGC PWM generator. Recovers the 8-bit gain-control value from a PWM waveform: measures high-time over frames of 2^PRD_W clocks and averages over 1, 2, 4 or 8 frames.
- Closes the AGC loop in the loopback test and monitors an externally driven gain-control line.
- Also reports a lock flag once successive measurements agree within a programmable tolerance.

Parameters:
- PRD_W, 7: PWM frame length is 2^PRD_W clocks (128, matching the generator's 128-step PWM). Value width is PRD_W+1.
- LOCK_CNT, 4: number of consecutive in-tolerance results required to assert pwm_lock.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pwm_in  in  1  asynchronous PWM input
- pwm_inv  in  1  1 = input is active-low; invert after synchroniser
- meas_en  in  1  measurement enable
- avg_prd  in  2  averaging depth, 2^avg_prd frames
- lock_tol  in  4  max |new - previous| result counted as in-tolerance
- pwm_val  out  8  averaged high-count, range 0..128
- pwm_vld  out  1  one-cycle strobe when pwm_val updates
- pwm_lock  out  1  measurement stable

Behaviour:
- Reset (synchronous, active-high): all registers, synchroniser stages and counters cleared. pwm_val=0, pwm_vld=0, pwm_lock=0, FSM=IDLE.
- Input path:
  - 2-FF synchroniser, then XOR with pwm_inv, giving signal s. Latency from pwm_in to s is 2 clocks.
  - Rising-edge detect on s uses a third register.
- FSM states IDLE, SYNC, MEAS:
  - IDLE: counters held at 0. meas_en=1 → SYNC.
  - SYNC: timeout counter runs 0..2*2^PRD_W-1.
    - Rising edge of s → MEAS, with the edge cycle as frame cycle 0.
    - Timeout reached (constant level, 0% or 100% duty) → MEAS starting next cycle.
  - MEAS: frame counter fc runs 0..2^PRD_W-1 and wraps. hi_cnt increments on every frame cycle with s=1.
    - At fc wrap: hi_cnt is added into the accumulator acc (PRD_W+4 bits) and hi_cnt is cleared. Frames run back to back with no resync.
  - meas_en=0 in any state → IDLE next cycle. Partial frame and acc are discarded, no pwm_vld is issued, pwm_lock clears, pwm_val holds.
- Averaging:
  - avg_prd is latched at the first frame of each averaging block; mid-block changes take effect at the next block.
  - After the 2^avg_prd-th frame ends (the cycle with fc = max): on the next clock, pwm_val = (acc + final hi_cnt) >> avg_prd (truncating), pwm_vld=1 for exactly that one cycle, and acc is cleared.
  - Result is at most 128, so no saturation is needed.
- Lock:
  - On each pwm_vld, compare with the previous result; the first result after IDLE has no previous and counts as out of tolerance.
  - |diff| <= lock_tol increments a lock counter, saturating at LOCK_CNT. Otherwise the counter clears and pwm_lock drops in the same cycle pwm_val updates.
  - pwm_lock=1 while the counter equals LOCK_CNT.
- Simultaneous events:
  - meas_en falling on the final frame cycle: IDLE wins, no strobe.
  - Rising edge in MEAS is ignored; alignment is free-running.
- Throughput: one result per 2^(PRD_W+avg_prd) clocks after the first.

Test Plan:
- Duty 32/128 aligned, avg_prd=0, pwm_inv=0, meas_en rises → first pwm_vld 2+1+128 clocks after the first edge; pwm_val=32 every 128 clocks thereafter.
- Same stimulus with pwm_inv=1 → pwm_val=96; pwm_in held 0 → SYNC times out after 256 clocks, then pwm_val=0. pwm_in held 1 with pwm_inv=0 → timeout, then pwm_val=128.
- avg_prd=2 with frames of duty 30,34,31,33 → one pwm_vld per 512 clocks, pwm_val=32. Duties 30,30,30,31 → pwm_val=30 (truncation).
- Lock: duty alternating 40/42, lock_tol=2, LOCK_CNT=4 → pwm_lock rises with the 5th result. Step to duty 60 → pwm_lock=0 in the same cycle pwm_val=60.
- meas_en dropped at fc=100 of a frame → no pwm_vld, pwm_lock=0, pwm_val holds. Re-enable → resync and a fresh full block.
- reset asserted mid-MEAS for 1 clock → next cycle all outputs 0, FSM IDLE (observe via no vld for more than 2 frames). Restart yields the correct value.
